iob_pcie_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one PCIe TX channel interface (CHNL_TX_*) among N_REQ local requesters, each presenting an identical TX-style request interface. The arbiter grants one requester per transaction, latches its length, offset and last flag, muxes its data onto the channel, and counts transferred 32-bit words to decide when the transaction ends. It sits between the user cores and the PCIe channel port, in the same clock domain as the channel.

---
 rtl/iob_pcie_tx_arbiter_if.sv | 66 ++++++
 rtl/iob_pcie_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_iob_pcie_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_pcie_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// iob_pcie_tx_arbiter_if
//
// Bundles the requester-side TX request bus and the PCIe channel TX bus that
// the arbiter connects together.
//
//   master : the arbiter. Consumes the requester requests and the channel
//            handshakes, and drives the acknowledges, read enables, channel
//            request/data and the grant vector.
//   slave  : the environment (user cores plus channel port). This is the
//            mirror image of master.
//
// Parameters
//   C_PCI_DATA_WIDTH : channel data width in bits (32, 64 or 128)
//   N_REQ            : number of requesters (2..4)
// ---------------------------------------------------------------------------
interface iob_pcie_tx_arbiter_if #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int N_REQ            = 2
);

  // requester side
  logic [N_REQ-1:0]                  REQ_TX;
  logic [N_REQ-1:0]                  REQ_TX_ACK;
  logic [N_REQ-1:0]                  REQ_TX_LAST;
  logic [32*N_REQ-1:0]               REQ_TX_LEN;
  logic [31*N_REQ-1:0]               REQ_TX_OFF;
  logic [C_PCI_DATA_WIDTH*N_REQ-1:0] REQ_TX_DATA;
  logic [N_REQ-1:0]                  REQ_TX_DATA_VALID;
  logic [N_REQ-1:0]                  REQ_TX_DATA_REN;

  // channel side
  logic                              CHNL_TX_CLK;
  logic                              CHNL_TX;
  logic                              CHNL_TX_ACK;
  logic                              CHNL_TX_LAST;
  logic [31:0]                       CHNL_TX_LEN;
  logic [30:0]                       CHNL_TX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0]       CHNL_TX_DATA;
  logic                              CHNL_TX_DATA_VALID;
  logic                              CHNL_TX_DATA_REN;

  // arbitration status
  logic [N_REQ-1:0]                  GRANT;

  modport master (
    input  REQ_TX, REQ_TX_LAST, REQ_TX_LEN, REQ_TX_OFF,
    input  REQ_TX_DATA, REQ_TX_DATA_VALID,
    input  CHNL_TX_ACK, CHNL_TX_DATA_REN,
    output REQ_TX_ACK, REQ_TX_DATA_REN,
    output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    output CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    output GRANT
  );

  modport slave (
    output REQ_TX, REQ_TX_LAST, REQ_TX_LEN, REQ_TX_OFF,
    output REQ_TX_DATA, REQ_TX_DATA_VALID,
    output CHNL_TX_ACK, CHNL_TX_DATA_REN,
    input  REQ_TX_ACK, REQ_TX_DATA_REN,
    input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    input  CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    input  GRANT
  );

endinterface

// File: rtl/iob_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// iob_pcie_tx_arbiter
//
// Round-robin arbiter sharing one PCIe TX channel among N_REQ requesters.
// One requester is granted per transaction. Its length, offset and last flag
// are latched at grant time, and its data/valid/read-enable are routed to the
// channel. The number of 32-bit words moved is counted so the arbiter knows
// when the transaction has ended.
//
// Ports
//   CLK  : sole clock (also forwarded as CHNL_TX_CLK)
//   RST  : asynchronous, active-high reset
//   bus  : iob_pcie_tx_arbiter_if.master
//          - REQ_TX*  : per-requester request buses (packed slices)
//          - CHNL_TX* : shared channel TX bus
//          - GRANT    : one-hot grant, zero when idle
//
// Parameters
//   C_PCI_DATA_WIDTH : channel data width (32, 64, 128)
//   N_REQ            : number of requesters (2..4)
// ---------------------------------------------------------------------------
module iob_pcie_tx_arbiter #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int N_REQ            = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  iob_pcie_tx_arbiter_if.master bus
);

  localparam int          PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [32:0] BEAT_WORDS = 33'(C_PCI_DATA_WIDTH / 32);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;

  logic [N_REQ-1:0]            grant;
  logic [PTR_W-1:0]            gidx;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            ptr_inc;
  logic [31:0]                 len_q;
  logic [30:0]                 off_q;
  logic                        last_q;
  // One bit wider than LEN so a length near 2^32 cannot wrap the count.
  logic [32:0]                 cnt;
  logic [32:0]                 cnt_inc;

  logic                        win_found;
  logic [PTR_W-1:0]            win_idx;
  logic [N_REQ-1:0]            win_onehot;

  logic                        valid_g;
  logic                        beat;
  logic                        xfer_end;
  logic [C_PCI_DATA_WIDTH-1:0] data_mux;

  // -------------------------------------------------------------------------
  // Winner selection: first pending request scanning upward from ptr,
  // wrapping past the top requester.
  // -------------------------------------------------------------------------
  always_comb begin : pick
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!win_found && bus.REQ_TX[PTR_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win_idx;

  // Round-robin pointer moves to the requester after the one just served.
  assign ptr_inc = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  // -------------------------------------------------------------------------
  // Granted-requester routing
  // -------------------------------------------------------------------------
  always_comb begin : data_sel
    data_mux = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        data_mux = data_mux | bus.REQ_TX_DATA[C_PCI_DATA_WIDTH*i +: C_PCI_DATA_WIDTH];
      end
    end
  end

  assign valid_g  = |(bus.REQ_TX_DATA_VALID & grant);
  assign beat     = (state == XFER) && valid_g && bus.CHNL_TX_DATA_REN;
  assign cnt_inc  = cnt + BEAT_WORDS;
  // A short final beat still counts as a full beat, hence >= rather than ==.
  assign xfer_end = beat && (cnt_inc >= {1'b0, len_q});

  assign bus.CHNL_TX_CLK  = CLK;
  assign bus.CHNL_TX_DATA = data_mux;
  assign bus.GRANT        = grant;

  // -------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin : fsm_comb
    state_nxt              = state;
    bus.CHNL_TX            = 1'b0;
    bus.CHNL_TX_LAST       = 1'b0;
    bus.CHNL_TX_LEN        = '0;
    bus.CHNL_TX_OFF        = '0;
    bus.CHNL_TX_DATA_VALID = 1'b0;
    bus.REQ_TX_ACK         = '0;
    bus.REQ_TX_DATA_REN    = '0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        bus.CHNL_TX      = 1'b1;
        bus.CHNL_TX_LAST = last_q;
        bus.CHNL_TX_LEN  = len_q;
        bus.CHNL_TX_OFF  = off_q;
        bus.REQ_TX_ACK   = grant & {N_REQ{bus.CHNL_TX_ACK}};
        if (bus.CHNL_TX_ACK) begin
          state_nxt = (len_q == 32'd0) ? DONE : XFER;
        end
      end

      XFER: begin
        bus.CHNL_TX            = 1'b1;
        bus.CHNL_TX_LAST       = last_q;
        bus.CHNL_TX_LEN        = len_q;
        bus.CHNL_TX_OFF        = off_q;
        bus.CHNL_TX_DATA_VALID = valid_g;
        bus.REQ_TX_DATA_REN    = grant & {N_REQ{bus.CHNL_TX_DATA_REN}};
        if (xfer_end) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, grant and latched transaction fields
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      ptr    <= '0;
      len_q  <= '0;
      off_q  <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && win_found) begin
        grant  <= win_onehot;
        gidx   <= win_idx;
        len_q  <= bus.REQ_TX_LEN[32*win_idx +: 32];
        off_q  <= bus.REQ_TX_OFF[31*win_idx +: 31];
        last_q <= bus.REQ_TX_LAST[win_idx];
        cnt    <= '0;
      end

      if (beat) begin
        cnt <= cnt_inc;
      end

      // Grant drops as the transaction closes so DONE already shows idle
      // outputs; the pointer advances at the same moment.
      if (state != DONE && state_nxt == DONE) begin
        grant <= '0;
        ptr   <= ptr_inc;
      end
    end
  end

endmodule

// File: tb/tb_iob_pcie_tx_arbiter.sv
module tb_iob_pcie_tx_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  iob_pcie_tx_arbiter_if #(.C_PCI_DATA_WIDTH(32), .N_REQ(2)) bus32 ();
  iob_pcie_tx_arbiter_if #(.C_PCI_DATA_WIDTH(64), .N_REQ(2)) bus64 ();

  iob_pcie_tx_arbiter #(.C_PCI_DATA_WIDTH(32), .N_REQ(2)) dut32 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus32)
  );

  iob_pcie_tx_arbiter #(.C_PCI_DATA_WIDTH(64), .N_REQ(2)) dut64 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus64)
  );

  int tests  = 0;
  int failed = 0;

  int         widx [2];
  logic [1:0] ren_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int i, input int w);
    return 32'hA000_0000 | (32'(i) << 24) | 32'(w);
  endfunction

  // Runs one transaction on the 32-bit arbiter with a simple channel model
  // (ACK once per request, REN and requester VALID optionally random).
  task automatic xfer32(input int budget, input bit throttle, input int drop_at,
                        output int beats, output bit ended);
    bit acked;
    bit seen_hi;
    int gi;
    beats   = 0;
    ended   = 1'b0;
    acked   = 1'b0;
    seen_hi = 1'b0;
    gi      = 0;
    for (int c = 0; c < budget && !ended; c++) begin
      @(negedge CLK);
      bus32.CHNL_TX_ACK      = bus32.CHNL_TX && !acked;
      bus32.CHNL_TX_DATA_REN = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 2; i++) begin
        bus32.REQ_TX_DATA_VALID[i]   = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus32.REQ_TX_DATA[32*i +: 32] = data_of(i, widx[i]);
      end
      #1;
      if (bus32.CHNL_TX_ACK) acked = 1'b1;
      ren_seen = ren_seen | bus32.REQ_TX_DATA_REN;
      if (bus32.CHNL_TX) begin
        seen_hi = 1'b1;
        gi = (bus32.GRANT == 2'b10) ? 1 : 0;
      end
      if (bus32.CHNL_TX_DATA_VALID && bus32.CHNL_TX_DATA_REN) begin
        chk("xfer_beat_data", 64'(bus32.CHNL_TX_DATA), 64'(data_of(gi, widx[gi])));
        widx[gi]++;
        beats++;
        if (beats == drop_at) bus32.REQ_TX[gi] = 1'b0;
      end
      if (seen_hi && !bus32.CHNL_TX) ended = 1'b1;
    end
  endtask

  initial begin
    int         beats;
    bit         ended;
    bit         acked;
    bit         seen;
    bit         prev;
    int         pulses;
    int         low_run;
    int         lastbeat;
    int         fallc;
    logic [1:0] order [4];
    int         gaps  [3];

    // all environment-driven signals start at zero
    bus32.REQ_TX = '0;  bus32.REQ_TX_LAST = '0;  bus32.REQ_TX_LEN = '0;
    bus32.REQ_TX_OFF = '0;  bus32.REQ_TX_DATA = '0;  bus32.REQ_TX_DATA_VALID = '0;
    bus32.CHNL_TX_ACK = 1'b0;  bus32.CHNL_TX_DATA_REN = 1'b0;
    bus64.REQ_TX = '0;  bus64.REQ_TX_LAST = '0;  bus64.REQ_TX_LEN = '0;
    bus64.REQ_TX_OFF = '0;  bus64.REQ_TX_DATA = '0;  bus64.REQ_TX_DATA_VALID = '0;
    bus64.CHNL_TX_ACK = 1'b0;  bus64.CHNL_TX_DATA_REN = 1'b0;
    widx[0] = 0;  widx[1] = 0;
    ren_seen = '0;

    // ---- reset state (requests and REN driven to expose ungated outputs)
    bus32.REQ_TX = 2'b11;  bus32.CHNL_TX_ACK = 1'b1;  bus32.CHNL_TX_DATA_REN = 1'b1;
    bus32.REQ_TX_DATA_VALID = 2'b11;  bus32.REQ_TX_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_chnl_tx",   64'(bus32.CHNL_TX), 64'd0);
    chk("rst_grant",     64'(bus32.GRANT), 64'd0);
    chk("rst_ack",       64'(bus32.REQ_TX_ACK), 64'd0);
    chk("rst_ren",       64'(bus32.REQ_TX_DATA_REN), 64'd0);
    chk("rst_valid",     64'(bus32.CHNL_TX_DATA_VALID), 64'd0);
    chk("rst_data",      64'(bus32.CHNL_TX_DATA), 64'd0);
    chk("rst_len",       64'(bus32.CHNL_TX_LEN), 64'd0);
    chk("rst_tx64",      64'(bus64.CHNL_TX), 64'd0);
    chk("chnl_clk",      64'(bus32.CHNL_TX_CLK), 64'(CLK));
    bus32.REQ_TX = '0;  bus32.CHNL_TX_ACK = 1'b0;  bus32.CHNL_TX_DATA_REN = 1'b0;
    bus32.REQ_TX_DATA_VALID = '0;  bus32.REQ_TX_DATA = '0;
    @(negedge CLK);
    RST = 1'b0;

    // ---- both requesters from reset, LEN=2: grant order 0,1,0,1, 2-cycle gaps
    bus32.REQ_TX_LEN = {32'd2, 32'd2};
    bus32.REQ_TX_DATA = {32'h2222_0000, 32'h1111_0000};
    bus32.REQ_TX_DATA_VALID = 2'b11;
    bus32.CHNL_TX_DATA_REN = 1'b1;
    pulses = 0;  low_run = 0;  prev = 1'b0;  acked = 1'b0;  beats = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (k == 0)  bus32.REQ_TX = 2'b11;
      if (k == 19) bus32.REQ_TX = 2'b00;
      bus32.CHNL_TX_ACK = bus32.CHNL_TX && !acked;
      #1;
      if (bus32.CHNL_TX_ACK) acked = 1'b1;
      if (bus32.CHNL_TX && !prev) begin
        if (pulses > 0 && pulses < 4) gaps[pulses-1] = low_run;
        if (pulses < 4) order[pulses] = bus32.GRANT;
        pulses++;
      end
      if (!bus32.CHNL_TX) begin
        low_run++;
        acked = 1'b0;
      end else begin
        low_run = 0;
      end
      if (bus32.CHNL_TX_DATA_VALID && bus32.CHNL_TX_DATA_REN) begin
        chk("rr_beat_data", 64'(bus32.CHNL_TX_DATA),
            (bus32.GRANT == 2'b01) ? 64'h1111_0000 : 64'h2222_0000);
        beats++;
      end
      prev = bus32.CHNL_TX;
    end
    bus32.CHNL_TX_ACK = 1'b0;
    chk("rr_pulses", 64'(pulses), 64'd4);
    chk("rr_order0", 64'(order[0]), 64'b01);
    chk("rr_order1", 64'(order[1]), 64'b10);
    chk("rr_order2", 64'(order[2]), 64'b01);
    chk("rr_order3", 64'(order[3]), 64'b10);
    chk("rr_gap0",   64'(gaps[0]), 64'd2);
    chk("rr_gap1",   64'(gaps[1]), 64'd2);
    chk("rr_gap2",   64'(gaps[2]), 64'd2);
    chk("rr_beats",  64'(beats), 64'd8);

    // ---- single requester 0, LEN=4, ACK after 2 cycles, REN always high
    @(negedge CLK);
    bus32.REQ_TX = 2'b01;
    bus32.REQ_TX_LEN = {32'd0, 32'd4};
    bus32.REQ_TX_OFF = {31'd0, 31'h7};
    bus32.REQ_TX_LAST = 2'b01;
    bus32.REQ_TX_DATA_VALID = 2'b01;
    bus32.CHNL_TX_DATA_REN = 1'b1;
    bus32.REQ_TX_DATA = {32'h0, data_of(0, 0)};
    #1;
    chk("t1_idle_tx", 64'(bus32.CHNL_TX), 64'd0);
    @(negedge CLK); #1;
    chk("t1_req_tx",   64'(bus32.CHNL_TX), 64'd1);
    chk("t1_grant",    64'(bus32.GRANT), 64'b01);
    chk("t1_len",      64'(bus32.CHNL_TX_LEN), 64'd4);
    chk("t1_off",      64'(bus32.CHNL_TX_OFF), 64'h7);
    chk("t1_last",     64'(bus32.CHNL_TX_LAST), 64'd1);
    chk("t1_ack_low",  64'(bus32.REQ_TX_ACK), 64'b00);
    chk("t1_ren_req",  64'(bus32.REQ_TX_DATA_REN), 64'b00);
    @(negedge CLK);
    bus32.CHNL_TX_ACK = 1'b1;
    #1;
    chk("t1_ack_comb", 64'(bus32.REQ_TX_ACK), 64'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus32.CHNL_TX_ACK = 1'b0;
      bus32.REQ_TX_DATA[31:0] = data_of(0, k);
      #1;
      chk("t1_valid", 64'(bus32.CHNL_TX_DATA_VALID), 64'd1);
      chk("t1_data",  64'(bus32.CHNL_TX_DATA), 64'(data_of(0, k)));
      chk("t1_ren",   64'(bus32.REQ_TX_DATA_REN), 64'b01);
    end
    @(negedge CLK);
    bus32.REQ_TX = 2'b00;
    #1;
    chk("t1_done_tx",    64'(bus32.CHNL_TX), 64'd0);
    chk("t1_done_grant", 64'(bus32.GRANT), 64'd0);
    chk("t1_done_ren",   64'(bus32.REQ_TX_DATA_REN), 64'b00);
    chk("t1_done_valid", 64'(bus32.CHNL_TX_DATA_VALID), 64'd0);
    @(negedge CLK); #1;
    chk("t1_idle2_tx", 64'(bus32.CHNL_TX), 64'd0);

    // ---- 64-bit channel, LEN=5: three beats, ends on the third
    bus64.REQ_TX_LEN = {32'd0, 32'd5};
    bus64.REQ_TX_DATA = {64'h0, 64'h0123_4567_89AB_CDEF};
    bus64.REQ_TX_DATA_VALID = 2'b01;
    bus64.CHNL_TX_DATA_REN = 1'b1;
    acked = 1'b0;  seen = 1'b0;  ended = 1'b0;  beats = 0;  lastbeat = -10;  fallc = -1;
    for (int c = 0; c < 20 && !ended; c++) begin
      @(negedge CLK);
      if (c == 0) bus64.REQ_TX = 2'b01;
      bus64.CHNL_TX_ACK = bus64.CHNL_TX && !acked;
      #1;
      if (bus64.CHNL_TX_ACK) acked = 1'b1;
      if (bus64.CHNL_TX) seen = 1'b1;
      if (bus64.CHNL_TX_DATA_VALID && bus64.CHNL_TX_DATA_REN) begin
        chk("w64_data", bus64.CHNL_TX_DATA, 64'h0123_4567_89AB_CDEF);
        beats++;
        lastbeat = c;
      end
      if (seen && !bus64.CHNL_TX) begin
        ended = 1'b1;
        fallc = c;
        bus64.REQ_TX = 2'b00;
      end
    end
    chk("w64_ended",    64'(ended), 64'd1);
    chk("w64_beats",    64'(beats), 64'd3);
    chk("w64_end_lat",  64'(fallc - lastbeat), 64'd1);

    // ---- throttled LEN=16 on requester 1, which drops REQ_TX mid-transfer
    bus32.REQ_TX_LEN = {32'd16, 32'd0};
    bus32.REQ_TX_LAST = 2'b00;
    widx[0] = 0;  widx[1] = 0;
    ren_seen = '0;
    @(negedge CLK);
    bus32.REQ_TX = 2'b10;
    xfer32(400, 1'b1, 5, beats, ended);
    chk("thr_ended",     64'(ended), 64'd1);
    chk("thr_beats",     64'(beats), 64'd16);
    chk("thr_words1",    64'(widx[1]), 64'd16);
    chk("thr_ren0",      64'(ren_seen[0]), 64'd0);
    chk("thr_req_drop",  64'(bus32.REQ_TX), 64'b00);
    chk("thr_grant_end", 64'(bus32.GRANT), 64'd0);

    // ---- LEN=0: ACK goes straight to DONE, no read enable
    @(negedge CLK);
    bus32.REQ_TX = 2'b01;
    bus32.REQ_TX_LEN = {32'd0, 32'd0};
    bus32.REQ_TX_DATA_VALID = 2'b11;
    bus32.CHNL_TX_DATA_REN = 1'b1;
    #1;
    chk("z_idle_tx", 64'(bus32.CHNL_TX), 64'd0);
    @(negedge CLK);
    bus32.CHNL_TX_ACK = 1'b1;
    #1;
    chk("z_req_tx",  64'(bus32.CHNL_TX), 64'd1);
    chk("z_ack",     64'(bus32.REQ_TX_ACK), 64'b01);
    chk("z_ren_req", 64'(bus32.REQ_TX_DATA_REN), 64'b00);
    @(negedge CLK);
    bus32.CHNL_TX_ACK = 1'b0;
    bus32.REQ_TX = 2'b00;
    #1;
    chk("z_done_tx",    64'(bus32.CHNL_TX), 64'd0);
    chk("z_done_grant", 64'(bus32.GRANT), 64'd0);
    chk("z_done_ren",   64'(bus32.REQ_TX_DATA_REN), 64'b00);
    chk("z_done_valid", 64'(bus32.CHNL_TX_DATA_VALID), 64'd0);

    // ---- reset during XFER at word 3 of 8 (pointer is at requester 1 here)
    @(negedge CLK);
    bus32.REQ_TX = 2'b11;
    bus32.REQ_TX_LEN = {32'd8, 32'd8};
    bus32.REQ_TX_DATA = {data_of(1, 0), data_of(0, 0)};
    #1;
    chk("r_idle_tx", 64'(bus32.CHNL_TX), 64'd0);
    @(negedge CLK);
    bus32.CHNL_TX_ACK = 1'b1;
    #1;
    chk("r_grant1", 64'(bus32.GRANT), 64'b10);
    chk("r_ack1",   64'(bus32.REQ_TX_ACK), 64'b10);
    for (int b = 0; b < 4; b++) begin
      @(negedge CLK);
      bus32.CHNL_TX_ACK = 1'b0;
      bus32.REQ_TX_DATA[63:32] = data_of(1, b);
      #1;
      chk("r_data", 64'(bus32.CHNL_TX_DATA), 64'(data_of(1, b)));
      chk("r_ren",  64'(bus32.REQ_TX_DATA_REN), 64'b10);
    end
    bus32.CHNL_TX_ACK = 1'b1;
    RST = 1'b1;
    #1;
    chk("r_async_tx",    64'(bus32.CHNL_TX), 64'd0);
    chk("r_async_valid", 64'(bus32.CHNL_TX_DATA_VALID), 64'd0);
    chk("r_async_ack",   64'(bus32.REQ_TX_ACK), 64'b00);
    chk("r_async_ren",   64'(bus32.REQ_TX_DATA_REN), 64'b00);
    chk("r_async_grant", 64'(bus32.GRANT), 64'b00);
    chk("r_async_data",  64'(bus32.CHNL_TX_DATA), 64'd0);
    @(negedge CLK);
    bus32.CHNL_TX_ACK = 1'b0;
    RST = 1'b0;
    #1;
    chk("r_rel_tx", 64'(bus32.CHNL_TX), 64'd0);
    @(negedge CLK); #1;
    chk("r_next_tx",    64'(bus32.CHNL_TX), 64'd1);
    chk("r_next_grant", 64'(bus32.GRANT), 64'b01);

    RST = 1'b1;
    bus32.REQ_TX = 2'b00;
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
